// File: rtl/memory_stage.sv
// MEM stage: branch resolution, word-organised data memory,
// and the MEM/WB pipeline register.
module memory_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteM,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic          MemtoRegM,
  input  logic          BranchM,
  input  logic          BNEM,
  input  logic          JMPM,
  input  logic          ZeroM,
  input  logic [31:0]   ALUResultM,
  input  logic [31:0]   ReadData2_M,
  input  logic [4:0]    WriteAddr_M,
  input  logic [31:0]   PCTargetM,
  output logic          PCSrcM,
  output logic [31:0]   PCTargetOut,
  output logic          RegWriteW,
  output logic          MemtoRegW,
  output logic [31:0]   ReadDataW,
  output logic [31:0]   ALUResultW,
  output logic [4:0]    WriteAddr_W,
  output logic          MisalignErr
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          aligned;
  logic          mem_we;
  logic          mem_re;

  assign PCSrcM      = (BranchM & ZeroM) | (BNEM & ~ZeroM) | JMPM;
  assign PCTargetOut = PCTargetM;

  // Upper address bits are dropped, so accesses alias modulo DEPTH*4.
  assign idx     = ALUResultM[AW+1:2];
  assign aligned = (ALUResultM[1:0] == 2'b00);
  assign mem_we  = MemWriteM & aligned & rst;
  assign mem_re  = MemReadM & aligned;

  // No reset on the array: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= ReadData2_M;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      ReadDataW   <= '0;
      ALUResultW  <= '0;
      WriteAddr_W <= '0;
      MisalignErr <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM;
      MemtoRegW   <= MemtoRegM;
      ReadDataW   <= mem_re ? mem[idx] : '0;
      ALUResultW  <= ALUResultM;
      WriteAddr_W <= WriteAddr_M;
      if ((MemReadM | MemWriteM) & ~aligned) begin
        MisalignErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: branch decode table plus
// hand-written memory, reset and misalignment sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemReadM, MemWriteM, MemtoRegM;
  logic        BranchM, BNEM, JMPM, ZeroM;
  logic [31:0] ALUResultM, ReadData2_M, PCTargetM;
  logic [4:0]  WriteAddr_M;
  logic        PCSrcM;
  logic [31:0] PCTargetOut;
  logic        RegWriteW, MemtoRegW, MisalignErr;
  logic [31:0] ReadDataW, ALUResultW;
  logic [4:0]  WriteAddr_W;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  memory_stage #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .BranchM(BranchM), .BNEM(BNEM), .JMPM(JMPM), .ZeroM(ZeroM),
    .ALUResultM(ALUResultM), .ReadData2_M(ReadData2_M),
    .WriteAddr_M(WriteAddr_M), .PCTargetM(PCTargetM),
    .PCSrcM(PCSrcM), .PCTargetOut(PCTargetOut),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .WriteAddr_W(WriteAddr_W), .MisalignErr(MisalignErr)
  );

  typedef struct {
    logic        br;
    logic        bne;
    logic        jmp;
    logic        zero;
    logic [31:0] tgt;
    logic        exp_src;
  } br_vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; MemtoRegM = 0;
    BranchM = 0; BNEM = 0; JMPM = 0; ZeroM = 0;
    ALUResultM = 0; ReadData2_M = 0; WriteAddr_M = 0; PCTargetM = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle();
    MemWriteM = 1; ALUResultM = a; ReadData2_M = d;
    cyc();
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    idle();
    MemReadM = 1; RegWriteM = 1; MemtoRegM = 1;
    ALUResultM = a; WriteAddr_M = rd;
    cyc();
  endtask

  br_vec_t bv [7];

  initial begin
    bv[0] = '{1, 0, 0, 1, 32'h0000_0040, 1};
    bv[1] = '{1, 0, 0, 0, 32'h0000_0040, 0};
    bv[2] = '{0, 1, 0, 0, 32'h0000_0040, 1};
    bv[3] = '{0, 1, 0, 1, 32'h0000_0080, 0};
    bv[4] = '{0, 0, 1, 1, 32'h0000_0100, 1};
    bv[5] = '{0, 0, 1, 0, 32'hFFFF_FFFC, 1};
    bv[6] = '{0, 0, 0, 0, 32'h1234_5678, 0};

    idle();
    rst = 0;
    cyc();
    cyc();
    chk("rst_regwrite", {31'b0, RegWriteW}, 0);
    chk("rst_memtoreg", {31'b0, MemtoRegW}, 0);
    chk("rst_readdata", ReadDataW, 0);
    chk("rst_aluresult", ALUResultW, 0);
    chk("rst_writeaddr", {27'b0, WriteAddr_W}, 0);
    chk("rst_misalign", {31'b0, MisalignErr}, 0);
    rst = 1;

    for (int i = 0; i < 7; i++) begin
      idle();
      BranchM = bv[i].br; BNEM = bv[i].bne;
      JMPM = bv[i].jmp; ZeroM = bv[i].zero;
      PCTargetM = bv[i].tgt;
      #1;
      chk($sformatf("pcsrc_%0d", i), {31'b0, PCSrcM},
          {31'b0, bv[i].exp_src});
      chk($sformatf("pctgt_%0d", i), PCTargetOut, bv[i].tgt);
    end
    cyc();

    store(32'h0000_000C, 32'hDEAD_BEEF);
    store(32'h0000_0010, 32'h1234_5678);
    chk("store_regwrite", {31'b0, RegWriteW}, 0);
    load(32'h0000_0010, 5'd7);
    chk("ld_data", ReadDataW, 32'h1234_5678);
    chk("ld_waddr", {27'b0, WriteAddr_W}, 7);
    chk("ld_regwrite", {31'b0, RegWriteW}, 1);
    chk("ld_memtoreg", {31'b0, MemtoRegW}, 1);
    chk("ld_alures", ALUResultW, 32'h0000_0010);
    chk("no_misalign", {31'b0, MisalignErr}, 0);

    // jump with a store still writes memory
    idle();
    JMPM = 1; MemWriteM = 1;
    ALUResultM = 32'h0000_0020; ReadData2_M = 32'h0BAD_F00D;
    #1;
    chk("jmp_pcsrc", {31'b0, PCSrcM}, 1);
    cyc();
    load(32'h0000_0020, 5'd1);
    chk("jmp_store", ReadDataW, 32'h0BAD_F00D);

    store(32'h0000_0400, 32'hA5A5_A5A5);
    load(32'h0000_0000, 5'd2);
    chk("wrap", ReadDataW, 32'hA5A5_A5A5);

    store(32'h0000_0008, 32'h0000_1111);
    idle();
    MemReadM = 1; MemWriteM = 1; RegWriteM = 1;
    ALUResultM = 32'h0000_0008; ReadData2_M = 32'h0000_2222;
    cyc();
    chk("rbw_old", ReadDataW, 32'h0000_1111);
    load(32'h0000_0008, 5'd3);
    chk("rbw_new", ReadDataW, 32'h0000_2222);

    idle();
    cyc();
    chk("bubble_regwrite", {31'b0, RegWriteW}, 0);
    chk("bubble_data", ReadDataW, 0);

    store(32'h0000_0013, 32'hFFFF_FFFF);
    chk("misalign_set", {31'b0, MisalignErr}, 1);
    load(32'h0000_0010, 5'd4);
    chk("misalign_nostore", ReadDataW, 32'h1234_5678);
    load(32'h0000_0011, 5'd9);
    chk("mis_ld_data", ReadDataW, 0);
    chk("mis_ld_regwrite", {31'b0, RegWriteW}, 1);
    for (int i = 0; i < 10; i++) begin
      load(32'h0000_0010, 5'd4);
      chk($sformatf("sticky_%0d", i), {31'b0, MisalignErr}, 1);
    end

    load(32'h0000_000C, 5'd6);
    chk("pre_rst_data", ReadDataW, 32'hDEAD_BEEF);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_data", ReadDataW, 0);
    chk("mid_rst_regwrite", {31'b0, RegWriteW}, 0);
    chk("mid_rst_memtoreg", {31'b0, MemtoRegW}, 0);
    chk("mid_rst_alures", ALUResultW, 0);
    chk("mid_rst_waddr", {27'b0, WriteAddr_W}, 0);
    chk("mid_rst_misalign", {31'b0, MisalignErr}, 0);
    store(32'h0000_000C, 32'h0000_0000);
    rst = 1;
    load(32'h0000_000C, 5'd6);
    chk("post_rst_data", ReadDataW, 32'hDEAD_BEEF);
    chk("post_rst_misalign", {31'b0, MisalignErr}, 0);

    idle();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
